// File: rtl/lstm_w_bank_buffer.sv
// lstm_w_bank_buffer
//   Loadable multi-gate weight store for the LSTM datapath. Holds GATE_NUM
//   banks of INPUT_SIZE words (UNITS_NUM*D_WL bits each, unit 0 in the LSBs)
//   in one flat RAM indexed by gate*INPUT_SIZE+word. Weights are written
//   through the load port while idle and streamed one bank at a time to the
//   MAC array under r_en_i, with valid/last/done framing and optional wrap.
//
// Ports
//   clk_i, rst_i          clock (posedge), synchronous active-high reset
//   ld_en_i/ld_gate_i/
//   ld_addr_i/ld_data_i   load request (accepted only in IDLE without start)
//   ld_err_o              1-cycle pulse: previous-cycle load was rejected
//   start_i, gate_sel_i   begin streaming bank gate_sel_i (IDLE only)
//   loop_en_i             wrap to word 0 at the end of the bank instead of stopping
//   abort_i               drop the stream, back to IDLE (beats r_en_i)
//   r_en_i                consume one word this cycle
//   w_o, w_vld_o, w_last_o registered weight word and its framing
//   busy_o                high while streaming
//   done_o                1-cycle pulse alongside the final w_last of a non-loop stream
module lstm_w_bank_buffer #(
    parameter int D_WL       = 24,
    parameter int INPUT_SIZE = 30,
    parameter int UNITS_NUM  = 2,
    parameter int GATE_NUM   = 4,
    parameter int AW         = 8,
    parameter int GW         = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ld_en_i,
    input  logic [GW-1:0]             ld_gate_i,
    input  logic [AW-1:0]             ld_addr_i,
    input  logic [UNITS_NUM*D_WL-1:0] ld_data_i,
    output logic                      ld_err_o,
    input  logic                      start_i,
    input  logic [GW-1:0]             gate_sel_i,
    input  logic                      loop_en_i,
    input  logic                      abort_i,
    input  logic                      r_en_i,
    output logic [UNITS_NUM*D_WL-1:0] w_o,
    output logic                      w_vld_o,
    output logic                      w_last_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int W     = UNITS_NUM * D_WL;
    localparam int DEPTH = GATE_NUM * INPUT_SIZE;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [GW-1:0]   gate_q;
    logic [AW-1:0]   rd_q;
    logic [W-1:0]    w_q;
    logic            w_vld_q, w_last_q, busy_q, done_q, ld_err_q;

    logic [W-1:0]    mem [DEPTH];

    logic            ld_ok;
    logic            sel_ok;
    logic            rd_last;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;

    // A load racing a start is refused so a stream never sees a half-updated bank.
    assign ld_ok   = ld_en_i && (state_q == IDLE) && !start_i
                     && (32'(ld_gate_i) < GATE_NUM)
                     && (32'(ld_addr_i) < INPUT_SIZE);
    assign sel_ok  = 32'(gate_sel_i) < GATE_NUM;
    assign rd_last = (rd_q == AW'(INPUT_SIZE - 1));
    assign wr_idx  = IW'(32'(ld_gate_i) * INPUT_SIZE + 32'(ld_addr_i));
    assign rd_idx  = IW'(32'(gate_q) * INPUT_SIZE + 32'(rd_q));

    // Weight storage is deliberately not reset: a reset must not cost a reload.
    always_ff @(posedge clk_i) begin
        if (ld_ok) mem[wr_idx] <= ld_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gate_q   <= '0;
            rd_q     <= '0;
            w_q      <= '0;
            w_vld_q  <= 1'b0;
            w_last_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            w_vld_q  <= 1'b0;
            w_last_q <= 1'b0;
            done_q   <= 1'b0;
            ld_err_q <= ld_en_i && !ld_ok;
            case (state_q)
                IDLE: begin
                    if (start_i && sel_ok) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        gate_q  <= gate_sel_i;
                        rd_q    <= '0;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (r_en_i) begin
                        w_q      <= mem[rd_idx];
                        w_vld_q  <= 1'b1;
                        w_last_q <= rd_last;
                        if (rd_last) begin
                            rd_q <= '0;
                            // loop_en_i is looked at only here, so it may change mid-bank.
                            if (!loop_en_i) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            rd_q <= rd_q + AW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_o      = w_q;
    assign w_vld_o  = w_vld_q;
    assign w_last_o = w_last_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign ld_err_o = ld_err_q;

endmodule
